// File: rtl/rfphoenix_vec_branch_eval_pkg.sv
// rfPhoenix shared definitions: instruction layout, branch condition enums,
// lane mask type and a small IEEE-single helper.
package rfPhoenixPkg;

   localparam int NLANES_DFLT = 4;

   typedef logic [NLANES_DFLT-1:0] lane_mask_t;

   localparam logic [6:0] OP_BCC  = 7'h28;
   localparam logic [6:0] OP_FBCC = 7'h29;

   typedef enum logic [2:0] {
      BC_LT  = 3'd0,
      BC_GE  = 3'd1,
      BC_LTU = 3'd2,
      BC_GEU = 3'd3,
      BC_BIT = 3'd4,
      BC_NEV = 3'd5,
      BC_EQ  = 3'd6,
      BC_NE  = 3'd7
   } bcc_cnd_t;

   typedef enum logic [2:0] {
      FBC_EQ  = 3'd0,
      FBC_NE  = 3'd1,
      FBC_LT  = 3'd2,
      FBC_LE  = 3'd3,
      FBC_NV4 = 3'd4,
      FBC_NV5 = 3'd5,
      FBC_UN  = 3'd6,
      FBC_ORD = 3'd7
   } fbcc_cnd_t;

   // Branch-format fields shared by Bcc and FBcc.
   typedef struct packed {
      logic [12:0] disp;
      logic [2:0]  cnd;
      logic [5:0]  Rb;
      logic [5:0]  Ra;
   } BrFields;

   typedef struct packed {
      BrFields    br;
      logic [6:0] opcode;
   } Instruction;

   // Exponent all ones with a non-zero fraction.
   function automatic logic is_nan32(input logic [31:0] f);
      return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/rfphoenix_vec_branch_eval_if.sv
// Issue-side and result-side handshake bundle of the vector branch evaluator.
interface rfphoenix_vec_branch_eval_if
   import rfPhoenixPkg::*;
#(
   parameter int NLANES = 4,
   parameter int WID    = 32
);
   logic                    flush_i;
   logic                    valid_i;
   logic                    ready_o;
   Instruction              ir_i;
   logic [NLANES*WID-1:0]   a_i;
   logic [NLANES*WID-1:0]   b_i;
   logic [NLANES-1:0]       mask_i;
   logic                    valid_o;
   logic                    ready_i;
   logic [NLANES-1:0]       taken_o;
   logic                    any_o;
   logic                    all_o;
   logic                    div_o;
   logic                    illegal_o;

   modport master (
      output flush_i, valid_i, ir_i, a_i, b_i, mask_i, ready_i,
      input  ready_o, valid_o, taken_o, any_o, all_o, div_o, illegal_o
   );

   modport slave (
      input  flush_i, valid_i, ir_i, a_i, b_i, mask_i, ready_i,
      output ready_o, valid_o, taken_o, any_o, all_o, div_o, illegal_o
   );
endinterface

// File: rtl/rfphoenix_vec_branch_eval_lane_cmp.sv
// Single-lane Bcc/FBcc condition evaluation (combinational).
// FP compare is only built when RFPHOENIX_FBCC_EN is defined.
`ifdef RFPHOENIX_FBCC_EN
module fpCompare32
   import rfPhoenixPkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        eq,
   output logic        lt,
   output logic        le,
   output logic        nan
);
   logic w_both_zero;
   logic w_eq_ord;
   logic w_lt_ord;

   assign nan         = is_nan32(a) | is_nan32(b);
   assign w_both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
   assign w_eq_ord    = w_both_zero | (a == b);

   // Sign-magnitude ordering; +0 and -0 compare equal.
   always_comb begin
      if (w_both_zero)        w_lt_ord = 1'b0;
      else if (a[31] != b[31]) w_lt_ord = a[31];
      else if (!a[31])        w_lt_ord = a[30:0] < b[30:0];
      else                    w_lt_ord = b[30:0] < a[30:0];
   end

   assign eq = ~nan & w_eq_ord;
   assign lt = ~nan & w_lt_ord;
   assign le = ~nan & (w_lt_ord | w_eq_ord);
endmodule
`endif

module rfphoenix_lane_cmp
   import rfPhoenixPkg::*;
#(
   parameter int WID = 32
)(
   input  Instruction     ir,
   input  logic [WID-1:0] a,
   input  logic [WID-1:0] b,
   output logic           raw
);
   logic [6:0]     w_bit_sel;
   logic [WID-1:0] w_bit_mask;
   logic           w_fp_raw;
   logic           w_unused_ir;

   assign w_unused_ir = ^{ir.br.disp, ir.br.Ra};
   assign w_bit_sel   = 7'({1'b0, ir.br.Rb} % 7'(WID));
   assign w_bit_mask  = {{(WID-1){1'b0}}, 1'b1} << w_bit_sel;

`ifdef RFPHOENIX_FBCC_EN
   logic w_feq, w_flt, w_fle, w_fnan;

   fpCompare32 u_fcmp (
      .a   (32'(a)),
      .b   (32'(b)),
      .eq  (w_feq),
      .lt  (w_flt),
      .le  (w_fle),
      .nan (w_fnan)
   );

   // FBcc condition select; NE and UN are the only NaN-true conditions.
   always_comb begin
      case (fbcc_cnd_t'(ir.br.cnd))
         FBC_EQ:  w_fp_raw = w_feq;
         FBC_NE:  w_fp_raw = ~w_feq;
         FBC_LT:  w_fp_raw = w_flt;
         FBC_LE:  w_fp_raw = w_fle;
         FBC_UN:  w_fp_raw = w_fnan;
         FBC_ORD: w_fp_raw = ~w_fnan;
         default: w_fp_raw = 1'b0;
      endcase
   end
`else
   assign w_fp_raw = 1'b0;
`endif

   // Integer condition select; non-branch opcodes never take.
   always_comb begin
      raw = 1'b0;
      if (ir.opcode == OP_BCC) begin
         case (bcc_cnd_t'(ir.br.cnd))
            BC_LT:   raw = $signed(a) <  $signed(b);
            BC_GE:   raw = $signed(a) >= $signed(b);
            BC_LTU:  raw = a <  b;
            BC_GEU:  raw = a >= b;
            BC_BIT:  raw = |(a & w_bit_mask);
            BC_EQ:   raw = a == b;
            BC_NE:   raw = a != b;
            default: raw = 1'b0;
         endcase
      end else if (ir.opcode == OP_FBCC) begin
         raw = w_fp_raw;
      end
   end
endmodule

// File: rtl/rfphoenix_vec_branch_eval.sv
// Two-stage lane-parallel branch condition evaluator with valid/ready and flush.
// Optional feature macro: RFPHOENIX_FBCC_EN (FBcc evaluation).
module rfphoenix_vec_branch_eval
   import rfPhoenixPkg::*;
#(
   parameter int NLANES = 4,
   parameter int WID    = 32
)(
   input logic                          clk,
   input logic                          rst_n,
   rfphoenix_vec_branch_eval_if.slave   bus
);
   logic [NLANES-1:0] w_raw;
   logic [NLANES-1:0] w_taken;
   logic              w_illegal;
   logic              w_adv2;
   logic              w_ready;
   logic              w_load1;
   logic              w_load2;

   logic              r_v1;
   logic              r_v2;
   logic [NLANES-1:0] r_raw_p1;
   logic [NLANES-1:0] r_mask_p1;
   logic              r_ill_p1;
   logic [NLANES-1:0] r_taken_p2;
   logic              r_any_p2;
   logic              r_all_p2;
   logic              r_div_p2;
   logic              r_ill_p2;

   for (genvar n = 0; n < NLANES; n++) begin : g_lane
      rfphoenix_lane_cmp #(.WID(WID)) u_cmp (
         .ir  (bus.ir_i),
         .a   (bus.a_i[n*WID +: WID]),
         .b   (bus.b_i[n*WID +: WID]),
         .raw (w_raw[n])
      );
   end

`ifdef RFPHOENIX_FBCC_EN
   assign w_illegal = (bus.ir_i.opcode != OP_BCC) && (bus.ir_i.opcode != OP_FBCC);
`else
   assign w_illegal = (bus.ir_i.opcode != OP_BCC);
`endif

   // Flush empties both stages, so input is always accepted (and dropped) then.
   assign w_adv2  = ~r_v2 | bus.ready_i;
   assign w_ready = ~r_v1 | w_adv2 | bus.flush_i;
   assign w_load1 = bus.valid_i & w_ready & ~bus.flush_i;
   assign w_load2 = r_v1 & w_adv2 & ~bus.flush_i;

   assign w_taken = r_raw_p1 & r_mask_p1;

   // Stage valid bits: flush wins, otherwise advance when downstream allows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (bus.flush_i) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else begin
         if (w_ready) r_v1 <= bus.valid_i;
         if (w_adv2)  r_v2 <= r_v1;
      end
   end

   // Stage 1: raw per-lane compare, predicate and illegal decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_raw_p1  <= '0;
         r_mask_p1 <= '0;
         r_ill_p1  <= 1'b0;
      end else if (w_load1) begin
         r_raw_p1  <= w_raw & {NLANES{~w_illegal}};
         r_mask_p1 <= bus.mask_i;
         r_ill_p1  <= w_illegal;
      end
   end

   // Stage 2: masked taken and any/all/divergence reduction; held while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_taken_p2 <= '0;
         r_any_p2   <= 1'b0;
         r_all_p2   <= 1'b0;
         r_div_p2   <= 1'b0;
         r_ill_p2   <= 1'b0;
      end else if (w_load2) begin
         r_taken_p2 <= w_taken;
         r_any_p2   <= |w_taken;
         r_all_p2   <= (w_taken == r_mask_p1) & (|r_mask_p1);
         r_div_p2   <= (|w_taken) & ~((w_taken == r_mask_p1) & (|r_mask_p1));
         r_ill_p2   <= r_ill_p1;
      end
   end

   assign bus.ready_o   = w_ready;
   assign bus.valid_o   = r_v2;
   assign bus.taken_o   = r_taken_p2;
   assign bus.any_o     = r_any_p2;
   assign bus.all_o     = r_all_p2;
   assign bus.div_o     = r_div_p2;
   assign bus.illegal_o = r_ill_p2;
endmodule

// File: tb/tb_rfphoenix_vec_branch_eval.sv
// Bench for rfphoenix_vec_branch_eval: directed scenarios plus random traffic
// against a lane-by-lane behavioural model and an in-flight beat queue.
module tb_rfphoenix_vec_branch_eval;
   import rfPhoenixPkg::*;

   localparam int NL = 4;
   localparam int W  = 32;
`ifdef RFPHOENIX_FBCC_EN
   localparam bit FEN = 1'b1;
`else
   localparam bit FEN = 1'b0;
`endif

   typedef struct {
      logic [NL-1:0] taken;
      logic          any_f;
      logic          all_f;
      logic          div_f;
      logic          ill;
      int            acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rfphoenix_vec_branch_eval_if #(.NLANES(NL), .WID(W)) bus ();

   rfphoenix_vec_branch_eval #(.NLANES(NL), .WID(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   n_out  = 0;
   exp_t q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic Instruction mk(input logic [6:0] op, input logic [2:0] cnd, input logic [5:0] rb);
      Instruction ir;
      ir = '0;
      ir.opcode = op;
      ir.br.cnd = cnd;
      ir.br.Rb  = rb;
      return ir;
   endfunction

   function automatic logic [NL*W-1:0] pk(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   // Reference: evaluate each lane from the condition tables, then reduce.
   function automatic exp_t model(input Instruction ir, input logic [NL*W-1:0] a, b, input logic [NL-1:0] m);
      exp_t e;
      bit is_int, is_fp;
      e.taken = '0;
      e.acc   = 0;
      is_int  = (ir.opcode == OP_BCC);
      is_fp   = (ir.opcode == OP_FBCC) && FEN;
      e.ill   = !(is_int || is_fp);
      for (int n = 0; n < NL; n++) begin
         logic [W-1:0] la, lb;
         longint sa, sb, ua, ub;
         bit t;
         la = a[n*W +: W];
         lb = b[n*W +: W];
         sa = longint'($signed(la));
         sb = longint'($signed(lb));
         ua = longint'({32'd0, la});
         ub = longint'({32'd0, lb});
         t  = 1'b0;
         if (is_int) begin
            case (ir.br.cnd)
               3'd0: t = sa < sb;
               3'd1: t = sa >= sb;
               3'd2: t = ua < ub;
               3'd3: t = ua >= ub;
               3'd4: t = ((la >> (int'(ir.br.Rb) % W)) & W'(1)) != '0;
               3'd6: t = la == lb;
               3'd7: t = la != lb;
               default: t = 1'b0;
            endcase
         end
`ifdef RFPHOENIX_FBCC_EN
         else if (is_fp) begin
            shortreal fa, fb;
            fa = $bitstoshortreal(la[31:0]);
            fb = $bitstoshortreal(lb[31:0]);
            case (ir.br.cnd)
               3'd0: t = (fa == fb);
               3'd1: t = !(fa == fb);
               3'd2: t = (fa < fb);
               3'd3: t = (fa <= fb);
               3'd6: t = (fa != fa) || (fb != fb);
               3'd7: t = !((fa != fa) || (fb != fb));
               default: t = 1'b0;
            endcase
         end
`endif
         e.taken[n] = t & m[n];
      end
      e.any_f = (e.taken != '0);
      e.all_f = (m != '0) && (e.taken == m);
      e.div_f = e.any_f && !e.all_f;
      return e;
   endfunction

   // One clock cycle: drive at negedge, check outputs against the queue, update at posedge.
   task automatic step(input logic vin, input Instruction ir, input logic [NL*W-1:0] a, b,
                       input logic [NL-1:0] m, input logic rdy, input logic fl, output logic acc);
      exp_t e;
      logic exp_rdy, vis;
      bus.valid_i = vin;
      bus.ir_i    = ir;
      bus.a_i     = a;
      bus.b_i     = b;
      bus.mask_i  = m;
      bus.ready_i = rdy;
      bus.flush_i = fl;
      #1;
      exp_rdy = (q.size() < 2) || rdy || fl;
      vis     = (q.size() > 0) && (cyc - q[0].acc >= 1);
      chk("ready_o", bus.ready_o, exp_rdy);
      chk("valid_o", bus.valid_o, vis);
      if (vis) begin
         chk("taken_o",   bus.taken_o,   q[0].taken);
         chk("any_o",     bus.any_o,     q[0].any_f);
         chk("all_o",     bus.all_o,     q[0].all_f);
         chk("div_o",     bus.div_o,     q[0].div_f);
         chk("illegal_o", bus.illegal_o, q[0].ill);
      end
      acc = vin && exp_rdy && !fl;
      e = model(ir, a, b, m);
      @(posedge clk);
      cyc++;
      if (vis && rdy) begin
         q.delete(0);
         n_out++;
      end
      if (fl) q.delete();
      else if (acc) begin
         e.acc = cyc;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic rdy);
      logic d;
      step(1'b0, '0, '0, '0, '0, rdy, 1'b0, d);
   endtask

   task automatic expect_out(input string tag, input logic [NL-1:0] tk, input logic an, al, dv, il);
      chk({tag, "_valid"}, bus.valid_o,   1'b1);
      chk({tag, "_taken"}, bus.taken_o,   tk);
      chk({tag, "_any"},   bus.any_o,     an);
      chk({tag, "_all"},   bus.all_o,     al);
      chk({tag, "_div"},   bus.div_o,     dv);
      chk({tag, "_ill"},   bus.illegal_o, il);
   endtask

   task automatic rand_beat(output Instruction ir, output logic [NL*W-1:0] a, b, output logic [NL-1:0] m);
      logic [31:0] fv [6];
      int sel;
      logic [6:0] op;
      fv  = '{32'h7FC00000, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000, 32'h7F800000};
      sel = int'($urandom_range(0, 8));
      op  = (sel < 5) ? OP_BCC : (sel < 8) ? OP_FBCC : 7'($urandom);
      ir  = mk(op, 3'($urandom), 6'($urandom));
      for (int n = 0; n < NL; n++) begin
         logic [31:0] la, lb;
         la = ($urandom_range(0, 2) == 0) ? fv[$urandom_range(0, 5)] : $urandom;
         lb = ($urandom_range(0, 2) == 0) ? fv[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 2) == 0) lb = la;
         a[n*W +: W] = la;
         b[n*W +: W] = lb;
      end
      m = NL'($urandom);
   endtask

   initial begin
      Instruction         ir;
      logic [NL*W-1:0]    a, b;
      logic [NL-1:0]      m;
      logic               acc;
      logic               saw_drop;
      int                 i, c, n0;
      Instruction         s_ir [8];
      logic [NL*W-1:0]    s_a [8];
      logic [NL*W-1:0]    s_b [8];
      logic [NL-1:0]      s_m [8];

      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.ir_i    = '0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.mask_i  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_valid", bus.valid_o, 1'b0);
      chk("rst_taken", bus.taken_o, '0);
      chk("rst_any",   bus.any_o, 1'b0);
      chk("rst_all",   bus.all_o, 1'b0);
      chk("rst_div",   bus.div_o, 1'b0);
      chk("rst_ill",   bus.illegal_o, 1'b0);
      chk("rst_ready", bus.ready_o, 1'b1);
      rst_n = 1'b1;
      idle(1'b1);

      // Bcc LT
      step(1'b1, mk(OP_BCC, 3'd0, 6'd0), pk(-1, 5, 3, 0), pk(0, 5, 7, 0), 4'b1111, 1'b0, 1'b0, acc);
      idle(1'b0);
      expect_out("lt", 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(1'b1);

      // Bcc EQ with partial and empty masks
      step(1'b1, mk(OP_BCC, 3'd6, 6'd0), pk(9, 8, 7, 6), pk(9, 8, 7, 6), 4'b0110, 1'b1, 1'b0, acc);
      step(1'b1, mk(OP_BCC, 3'd6, 6'd0), pk(9, 8, 7, 6), pk(9, 8, 7, 6), 4'b0000, 1'b1, 1'b0, acc);
      expect_out("eq", 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      expect_out("eq_m0", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1'b1);

      // FBcc NE / LT with a NaN in lane 0
      a = pk(32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
      b = pk(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
      step(1'b1, mk(OP_FBCC, 3'd1, 6'd0), a, b, 4'b0001, 1'b1, 1'b0, acc);
      step(1'b1, mk(OP_FBCC, 3'd2, 6'd0), a, b, 4'b0001, 1'b1, 1'b0, acc);
      expect_out("fne", FEN ? 4'b0001 : 4'b0000, FEN, FEN, 1'b0, !FEN);
      idle(1'b1);
      expect_out("flt", 4'b0000, 1'b0, 1'b0, 1'b0, !FEN);
      idle(1'b1);

      // Illegal opcode still flows
      step(1'b1, mk(7'h05, 3'd7, 6'd0), pk(1, 2, 3, 4), pk(5, 6, 7, 8), 4'b1111, 1'b1, 1'b0, acc);
      idle(1'b1);
      expect_out("illop", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(1'b1);

      // 8-beat stream, ready_i low for cycles 3..5
      for (int k = 0; k < 8; k++) rand_beat(s_ir[k], s_a[k], s_b[k], s_m[k]);
      n0 = n_out;
      i = 0;
      c = 0;
      saw_drop = 1'b0;
      while (i < 8 && c < 40) begin
         step(1'b1, s_ir[i], s_a[i], s_b[i], s_m[i], !(c >= 3 && c <= 5), 1'b0, acc);
         if (!bus.ready_o) saw_drop = 1'b1;
         if (acc) i++;
         c++;
      end
      chk("stream_accepted", 64'(i), 64'd8);
      c = 0;
      while (q.size() > 0 && c < 20) begin
         idle(1'b1);
         c++;
      end
      chk("stream_drained", 64'(q.size()), 64'd0);
      chk("stream_count", 64'(n_out - n0), 64'd8);
      chk("stream_ready_drop", saw_drop, 1'b1);

      // Flush with two beats in flight and valid_i high
      step(1'b1, mk(OP_BCC, 3'd7, 6'd0), pk(1, 1, 1, 1), pk(2, 2, 2, 2), 4'b1111, 1'b0, 1'b0, acc);
      step(1'b1, mk(OP_BCC, 3'd6, 6'd0), pk(1, 1, 1, 1), pk(1, 1, 1, 1), 4'b1111, 1'b0, 1'b0, acc);
      step(1'b1, mk(OP_BCC, 3'd2, 6'd0), pk(1, 1, 1, 1), pk(2, 2, 2, 2), 4'b1111, 1'b0, 1'b1, acc);
      chk("flush_valid", bus.valid_o, 1'b0);
      step(1'b1, mk(OP_BCC, 3'd4, 6'd3), pk(8, 0, 8, 0), pk(0, 0, 0, 0), 4'b1111, 1'b1, 1'b0, acc);
      chk("flush_next_lat1", bus.valid_o, 1'b0);
      idle(1'b1);
      expect_out("flush_next", 4'b0101, 1'b1, 1'b0, 1'b1, 1'b0);

      // Flush in the same cycle as the output is consumed
      rand_beat(ir, a, b, m);
      step(1'b1, ir, a, b, m, 1'b1, 1'b1, acc);
      chk("flush_cons_valid", bus.valid_o, 1'b0);
      idle(1'b1);
      chk("flush_cons_empty", bus.valid_o, 1'b0);

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         rand_beat(ir, a, b, m);
         step($urandom_range(0, 3) != 0, ir, a, b, m, $urandom_range(0, 3) != 0,
              $urandom_range(0, 24) == 0, acc);
      end

      // Asynchronous reset mid-stream
      for (int k = 0; k < 3; k++) begin
         rand_beat(ir, a, b, m);
         m = 4'b1111;
         step(1'b1, mk(OP_BCC, 3'd7, 6'd0), pk(1, 2, 3, 4), pk(4, 3, 2, 1), m, 1'b0, 1'b0, acc);
      end
      chk("pre_rst_valid", bus.valid_o, 1'b1);
      bus.ready_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.valid_o, 1'b0);
      chk("arst_taken", bus.taken_o, '0);
      chk("arst_any",   bus.any_o, 1'b0);
      chk("arst_all",   bus.all_o, 1'b0);
      chk("arst_div",   bus.div_o, 1'b0);
      chk("arst_ill",   bus.illegal_o, 1'b0);
      chk("arst_ready", bus.ready_o, 1'b1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(1'b1);
      for (int k = 0; k < 20; k++) begin
         rand_beat(ir, a, b, m);
         step(1'b1, ir, a, b, m, 1'b1, 1'b0, acc);
      end
      c = 0;
      while (q.size() > 0 && c < 20) begin
         idle(1'b1);
         c++;
      end
      chk("final_drained", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
